// File: rtl/mul_div_unit.sv
// RV32M multiply/divide execute unit: iterative shift-add multiply and restoring
// divide on magnitudes, with sign correction applied when the result is written.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [2:0]       MulDivOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic             Busy,
  output logic             Done,
  output logic             Zero,
  output logic             Negative,
  output logic             DivZero
);

  localparam int unsigned CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_CALC, S_FINISH} state_t;

  state_t               r_state, w_next;
  logic [WIDTH-1:0]     r_a, r_b;
  logic [2:0]           r_op;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_prod;
  logic [WIDTH-1:0]     r_mcand, r_quo, r_dvsr;
  logic [WIDTH:0]       r_rem;
  logic                 r_neg;

  logic                 w_is_div, w_a_sgn, w_b_sgn, w_neg_a, w_neg_b;
  logic [WIDTH-1:0]     w_abs_a, w_abs_b;
  logic                 w_div0, w_ovf, w_special;
  logic [WIDTH-1:0]     w_special_res;
  logic [WIDTH:0]       w_sum, w_shift, w_diff, w_rem_nx;
  logic [2*WIDTH-1:0]   w_prod_nx, w_prod_s;
  logic [WIDTH-1:0]     w_quo_nx, w_quo_s, w_rem_s, w_final;
  logic                 w_last;

  // Operand decode works on the latched copies so later input changes are harmless
  always_comb begin
    w_is_div  = r_op[2];
    w_a_sgn   = (r_op == 3'b001) || (r_op == 3'b010) || (r_op == 3'b100) || (r_op == 3'b110);
    w_b_sgn   = (r_op == 3'b001) || (r_op == 3'b100) || (r_op == 3'b110);
    w_neg_a   = w_a_sgn && r_a[WIDTH-1];
    w_neg_b   = w_b_sgn && r_b[WIDTH-1];
    w_abs_a   = w_neg_a ? -r_a : r_a;
    w_abs_b   = w_neg_b ? -r_b : r_b;
    w_div0    = w_is_div && (r_b == '0);
    w_ovf     = w_is_div && !r_op[0] && (r_a == {1'b1, {(WIDTH-1){1'b0}}}) && (r_b == '1);
    w_special = w_div0 || w_ovf;
    if (w_div0)
      w_special_res = r_op[1] ? r_a : '1;
    else
      w_special_res = r_op[1] ? '0 : r_a;
  end

  always_comb begin
    w_sum     = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
    w_prod_nx = {w_sum, r_prod[WIDTH-1:1]};
    w_shift   = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    w_diff    = w_shift - {1'b0, r_dvsr};
    w_rem_nx  = w_diff[WIDTH] ? w_shift : w_diff;
    w_quo_nx  = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
    w_prod_s  = r_neg ? -w_prod_nx : w_prod_nx;
    w_quo_s   = r_neg ? -w_quo_nx : w_quo_nx;
    w_rem_s   = r_neg ? -w_rem_nx[WIDTH-1:0] : w_rem_nx[WIDTH-1:0];
    if (w_is_div)
      w_final = r_op[1] ? w_rem_s : w_quo_s;
    else
      w_final = (r_op[1:0] == 2'b00) ? w_prod_s[WIDTH-1:0] : w_prod_s[2*WIDTH-1:WIDTH];
    w_last    = (r_cnt == CW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (Start) w_next = S_PREP;
      S_PREP:   w_next = w_special ? S_FINISH : S_CALC;
      S_CALC:   if (w_last) w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign Busy = (r_state == S_PREP) || (r_state == S_CALC);
  assign Done = (r_state == S_FINISH);

  // Result and flags are written on the edge entering FINISH so they are valid with Done
  always_ff @(posedge clk) begin
    if (rst) begin
      Result   <= '0;
      Zero     <= 1'b0;
      Negative <= 1'b0;
      DivZero  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_a  <= A;
            r_b  <= B;
            r_op <= MulDivOp;
          end
        end
        S_PREP: begin
          if (w_special) begin
            Result   <= w_special_res;
            Zero     <= (w_special_res == '0);
            Negative <= w_special_res[WIDTH-1];
            DivZero  <= w_div0;
          end else begin
            r_cnt   <= CW'(ITER);
            r_prod  <= {{WIDTH{1'b0}}, w_abs_b};
            r_mcand <= w_abs_a;
            r_quo   <= w_abs_a;
            r_dvsr  <= w_abs_b;
            r_rem   <= '0;
            r_neg   <= (w_is_div && r_op[1]) ? w_neg_a : (w_neg_a ^ w_neg_b);
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt - CW'(1);
          if (w_is_div) begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
          end else begin
            r_prod <= w_prod_nx;
          end
          if (w_last) begin
            Result   <= w_final;
            Zero     <= (w_final == '0);
            Negative <= w_final[WIDTH-1];
            DivZero  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed checks for mul_div_unit: vector table plus hand-written timing sequences.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic [2:0]  MulDivOp;
  logic [31:0] A, B;
  logic [31:0] Result;
  logic        Busy, Done, Zero, Negative, DivZero;

  int unsigned checks = 0;
  int unsigned errors = 0;

  mul_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk(clk), .rst(rst), .Start(Start), .MulDivOp(MulDivOp), .A(A), .B(B),
    .Result(Result), .Busy(Busy), .Done(Done), .Zero(Zero), .Negative(Negative),
    .DivZero(DivZero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          cyc;
    logic        dz;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int done_cyc;
    int busy_cnt;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    Start = 1'b1; MulDivOp = v.op; A = v.a; B = v.b;
    @(posedge clk);
    #1;
    Start = 1'b0; A = ~v.a; B = v.b ^ 32'h5a5a_a5a5; MulDivOp = ~v.op;
    done_cyc = 0;
    busy_cnt = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (Done) begin
        done_cyc = c;
        break;
      end
      if (Busy) busy_cnt++;
    end
    chk({tag, "_latency"}, done_cyc, v.cyc);
    chk({tag, "_busycnt"}, busy_cnt, v.cyc - 1);
    chk({tag, "_busy_in_done"}, {31'b0, Busy}, 32'd0);
    chk({tag, "_result"}, Result, v.res);
    chk({tag, "_zero"}, {31'b0, Zero}, {31'b0, v.res == 32'd0});
    chk({tag, "_neg"}, {31'b0, Negative}, {31'b0, v.res[31]});
    chk({tag, "_divzero"}, {31'b0, DivZero}, {31'b0, v.dz});
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'b0, Done}, 32'd0);
    chk({tag, "_hold"}, Result, v.res);
  endtask

  initial begin
    int done_cyc;
    int done_cnt;
    int busy_cnt;

    vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b0};
    vecs[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1'b0};
    vecs[2]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34, 1'b0};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 34, 1'b0};
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34, 1'b0};
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34, 1'b0};
    vecs[6]  = '{3'b101, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 34, 1'b0};
    vecs[7]  = '{3'b101, 32'h0000_0064, 32'h0000_0000, 32'hFFFF_FFFF, 2, 1'b1};
    vecs[8]  = '{3'b111, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 2, 1'b1};
    vecs[9]  = '{3'b000, 32'h0000_0002, 32'h0000_0003, 32'h0000_0006, 34, 1'b0};
    vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 1'b0};
    vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2, 1'b0};
    vecs[12] = '{3'b111, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 34, 1'b0};
    vecs[13] = '{3'b100, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 34, 1'b0};
    vecs[14] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 1'b0};
    vecs[15] = '{3'b100, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 2, 1'b1};
    vecs[16] = '{3'b110, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 2, 1'b1};
    vecs[17] = '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 34, 1'b0};
    vecs[18] = '{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 1'b0};

    rst = 1'b1; Start = 1'b1; MulDivOp = 3'b000; A = 32'd5; B = 32'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {31'b0, Busy}, 32'd0);
    chk("reset_done", {31'b0, Done}, 32'd0);
    chk("reset_result", Result, 32'd0);
    chk("reset_zero", {31'b0, Zero}, 32'd0);
    chk("reset_neg", {31'b0, Negative}, 32'd0);
    chk("reset_divzero", {31'b0, DivZero}, 32'd0);
    rst = 1'b0; Start = 1'b0;

    for (int i = 0; i < 19; i++) run_vec(i, vecs[i]);

    // Start pulses while busy and in the Done cycle must be ignored
    @(negedge clk);
    Start = 1'b1; MulDivOp = 3'b000; A = 32'd5; B = 32'd3;
    @(posedge clk);
    #1;
    Start = 1'b0;
    done_cyc = 0; done_cnt = 0; busy_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (Done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (Busy) busy_cnt++;
      if (c == 34) chk("ign_result", Result, 32'd15);
      Start = (c == 5) || (c == 33) || (c == 34);
    end
    chk("ign_done_cycle", done_cyc, 34);
    chk("ign_done_count", done_cnt, 1);
    chk("ign_busy_count", busy_cnt, 33);
    chk("ign_hold", Result, 32'd15);

    // Reset mid-operation aborts it; a Start right after reset is accepted
    @(negedge clk);
    Start = 1'b1; MulDivOp = 3'b000; A = 32'd5; B = 32'd3;
    @(posedge clk);
    #1;
    Start = 1'b0;
    done_cyc = 0; done_cnt = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (Done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (c == 11) begin
        chk("rst_busy", {31'b0, Busy}, 32'd0);
        chk("rst_done", {31'b0, Done}, 32'd0);
        chk("rst_result", Result, 32'd0);
        chk("rst_zero", {31'b0, Zero}, 32'd0);
      end
      if (c == 45) chk("rst_new_result", Result, 32'd42);
      rst   = (c == 10);
      Start = (c == 11);
      if (c == 11) begin
        A = 32'd6; B = 32'd7;
      end
    end
    chk("rst_done_cycle", done_cyc, 45);
    chk("rst_done_count", done_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
